// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS16 instruction-fetch stage.
// Owns the fetch PC, issues one word fetch at a time to instruction memory,
// buffers returned words in a small FIFO and feeds ID through a registered
// output stage that honours hazard stalls and ID-resolved branch redirects.
// Optional build macro: IF_PERF_CNT_EN adds saturating stall/bubble counters
// (perf_stall_cnt, perf_bubble_cnt).
//
// Memory handshake: imem_req is a single-cycle pulse with imem_addr valid in
// the same cycle; exactly one fetch may be outstanding, and its reply is the
// next imem_rvalid pulse (at least one cycle later, any latency). There is no
// ready/back-pressure on replies: a FIFO slot is reserved before the request
// is issued, so every accepted reply always has somewhere to go.
module if_fetch_stage #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [5:0]      branch_offset_imm,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instruction,
  output logic            instruction_decode_en,
  output logic [PC_W-1:0] id_pc,
  output logic [1:0]      dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_bubble_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  // Fetch FSM and PC
  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;

  // Returned-instruction FIFO
  logic [15:0]      fifo_data_q [FIFO_DEPTH];
  logic [PC_W-1:0]  fifo_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ID-facing output register
  logic [15:0]     instr_q, instr_d;
  logic            dec_en_q, dec_en_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;

  // Control terms
  logic              branch_go;
  logic              fifo_empty;
  logic              req_ok;
  logic              rsp_accept;
  logic              load_out;
  logic              pop;
  logic              fwd;
  logic              push;
  logic signed [5:0] off_s;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   target_pc;

  // Stall wins over a branch; ID re-asserts the branch once the stall clears.
  assign branch_go  = branch_taken & ~stall;
  assign fifo_empty = (count_q == '0);

  // A request needs a free FIFO slot and is withheld in a redirect cycle so
  // the branch target is fetched first on the next REQ.
  assign req_ok = (state_q == S_REQ) && (count_q < CNT_W'(FIFO_DEPTH)) && !branch_go;

  assign imem_req  = req_ok;
  assign imem_addr = req_ok ? fetch_pc_q : '0;

  // Only a reply to a live request in WAIT is kept; replies that land in
  // IDLE/REQ/DISCARD, or in the same cycle as a redirect, are dropped.
  assign rsp_accept = (state_q == S_WAIT) && imem_rvalid && !branch_go;

  // The output register refills whenever ID is not stalled. A reply that
  // arrives while the FIFO is empty is registered straight into the output
  // stage (never combinationally passed through), which is equivalent to a
  // push followed by a pop in the next cycle but one cycle sooner.
  assign load_out = !stall && !branch_go;
  assign pop      = load_out && !fifo_empty;
  assign fwd      = load_out && fifo_empty && rsp_accept;
  assign push     = rsp_accept && !fwd;

  // Branch target: word after the branch plus the signed offset, mod 2^PC_W.
  assign off_s     = branch_offset_imm;
  assign off_ext   = PC_W'(off_s);
  assign target_pc = id_pc_q + PC_W'(1) + off_ext;

  assign instruction           = instr_q;
  assign instruction_decode_en = dec_en_q;
  assign id_pc                 = id_pc_q;
  assign dbg_state             = state_q;

  // Next-state logic for the fetch FSM, fetch PC and captured request PC
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (branch_go) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (branch_go) begin
      fetch_pc_d = target_pc;
    end else if (req_ok) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
    end
    if (req_ok) begin
      req_pc_d = fetch_pc_q;
    end
  end

  // FIFO pointer and occupancy bookkeeping; a redirect empties the buffer
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_go) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Output register: hold on stall, clear on redirect, else pop/forward/bubble
  always_comb begin
    instr_d  = instr_q;
    dec_en_d = dec_en_q;
    id_pc_d  = id_pc_q;
    if (branch_go) begin
      instr_d  = 16'h0000;
      dec_en_d = 1'b0;
    end else if (!stall) begin
      if (pop) begin
        instr_d  = fifo_data_q[rd_ptr_q];
        id_pc_d  = fifo_pc_q[rd_ptr_q];
        dec_en_d = 1'b1;
      end else if (fwd) begin
        instr_d  = imem_rdata;
        id_pc_d  = req_pc_q;
        dec_en_d = 1'b1;
      end else begin
        instr_d  = 16'h0000;
        dec_en_d = 1'b0;
      end
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= 16'h0000;
      dec_en_q   <= 1'b0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      dec_en_q   <= dec_en_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] bubble_cnt_q;

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;

  // Saturating counters: stalled cycles, and unstalled cycles with no buffered word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (!stall && fifo_empty && (bubble_cnt_q != 16'hFFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule
